seven_stage_mem_hazard_tracker: RTL and testbench

//  Generates the memory hazards (d_mem_issue/recv_hazard or i_mem_issue/recv_hazard) consumed by the stall unit.
//  One instance sits per memory port (instruction, data), between the issue/receive stages and the memory interface.

---
 rtl/seven_stage_mem_hazard_tracker_if.sv | 33 +++
 rtl/seven_stage_mem_hazard_tracker.sv | 88 ++++++++
 tb/tb_seven_stage_mem_hazard_tracker.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/seven_stage_mem_hazard_tracker_if.sv
// Handshake bundle between the issue/receive stages, the stall unit and one
// memory port, as seen by seven_stage_mem_hazard_tracker.
interface seven_stage_mem_hazard_tracker_if #(
   parameter int unsigned CNT_W = 2
);
   logic             req_valid;
   logic             mem_ready;
   logic             rsp_valid;
   logic             flush_memory_issue;
   logic             flush_memory_receive;
   logic             issue_hazard;
   logic             recv_hazard;
   logic             req_fire;
   logic             rsp_accept;
   logic             rsp_drop;
   logic [CNT_W-1:0] outstanding;
   logic [CNT_W-1:0] drop_pending;
   logic             protocol_error;

   // Pipeline / memory side driving the tracker
   modport master (
      output req_valid, mem_ready, rsp_valid, flush_memory_issue, flush_memory_receive,
      input  issue_hazard, recv_hazard, req_fire, rsp_accept, rsp_drop,
             outstanding, drop_pending, protocol_error
   );

   // The tracker itself
   modport slave (
      input  req_valid, mem_ready, rsp_valid, flush_memory_issue, flush_memory_receive,
      output issue_hazard, recv_hazard, req_fire, rsp_accept, rsp_drop,
             outstanding, drop_pending, protocol_error
   );
endinterface

// File: rtl/seven_stage_mem_hazard_tracker.sv
// Per-memory-port hazard tracker. Counts in-order outstanding requests and
// turns requests flushed while in flight into pending drops so their late
// responses are discarded instead of reaching the pipeline.
// Optional protocol checker: define MEM_TRACKER_CHECK_EN.
module seven_stage_mem_hazard_tracker #(
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter int unsigned CNT_W           = 2
) (
   input  logic                          clock,
   input  logic                          reset,
   seven_stage_mem_hazard_tracker_if.slave bus
);

   logic [CNT_W-1:0] out_q;
   logic [CNT_W-1:0] drop_q;
   logic [CNT_W-1:0] out_after_rsp;
   logic [CNT_W-1:0] drop_after_rsp;
   logic [CNT_W-1:0] out_d;
   logic [CNT_W-1:0] drop_d;
   logic [CNT_W-1:0] live;
   logic             full;
   logic             fire;
   logic             consume;
   logic             accept;
   logic             drop;
   logic             hazard_issue;
   logic             hazard_recv;

   // Request/response decode and next counter values
   always_comb begin
      full           = (out_q == CNT_W'(MAX_OUTSTANDING));
      live           = out_q - drop_q;
      fire           = bus.req_valid & bus.mem_ready & ~full & ~bus.flush_memory_issue;
      hazard_issue   = bus.req_valid & ~bus.flush_memory_issue & (~bus.mem_ready | full);
      consume        = bus.rsp_valid & (out_q != '0);
      drop           = consume & (drop_q != '0);
      accept         = consume & (drop_q == '0);
      hazard_recv    = (live != '0) & ~accept;
      out_after_rsp  = out_q - CNT_W'(consume);
      drop_after_rsp = drop_q - CNT_W'(drop);
      out_d          = out_after_rsp + CNT_W'(fire);
      // A request fired in the flush cycle comes from the unflushed issue
      // stage, so only what remains after this cycle's response goes stale.
      drop_d         = bus.flush_memory_receive ? out_after_rsp : drop_after_rsp;
   end

   // Outstanding and stale-request counters
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         out_q  <= '0;
         drop_q <= '0;
      end else begin
         out_q  <= out_d;
         drop_q <= drop_d;
      end
   end

   assign bus.req_fire     = fire & reset;
   assign bus.issue_hazard = hazard_issue & reset;
   assign bus.rsp_accept   = accept & reset;
   assign bus.rsp_drop     = drop & reset;
   assign bus.recv_hazard  = hazard_recv & reset;
   assign bus.outstanding  = reset ? out_q : '0;
   assign bus.drop_pending = reset ? drop_q : '0;

`ifdef MEM_TRACKER_CHECK_EN
   logic err_q;
   logic spurious;
   logic overrun;

   assign spurious = bus.rsp_valid & (out_q == '0);
   assign overrun  = bus.rsp_valid & bus.mem_ready & bus.req_valid & full;

   // Sticky protocol violation flag, cleared only by reset
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         err_q <= 1'b0;
      end else if (spurious | overrun) begin
         err_q <= 1'b1;
      end
   end

   assign bus.protocol_error = err_q & reset;
`else
   assign bus.protocol_error = 1'b0;
`endif

endmodule

// File: tb/tb_seven_stage_mem_hazard_tracker.sv
// Self-checking bench for seven_stage_mem_hazard_tracker. A reference model
// keeps one entry per in-flight request (stale or live); expected outputs are
// queued when inputs are driven and compared when the DUT outputs settle.
// Honours MEM_TRACKER_CHECK_EN for the protocol_error expectation.
module tb_seven_stage_mem_hazard_tracker;

   localparam int unsigned MAX = 2;
   localparam int unsigned CW  = 2;

   typedef struct {
      int issue_hazard;
      int recv_hazard;
      int req_fire;
      int rsp_accept;
      int rsp_drop;
      int outstanding;
      int drop_pending;
      int protocol_error;
   } exp_t;

   logic clock;
   logic reset;
   int   tests;
   int   fails;
   exp_t sb[$];
   bit   stale_q[$];
   bit   model_err;

   seven_stage_mem_hazard_tracker_if #(.CNT_W(CW)) bus ();

   seven_stage_mem_hazard_tracker #(
      .MAX_OUTSTANDING(MAX),
      .CNT_W          (CW)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input int obs, input int exp);
      tests++;
      if (obs != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Drive one cycle of inputs, predict, compare, then advance the model
   task automatic step(input bit rst, input bit rv, input bit mr, input bit rsp,
                       input bit fi, input bit fr);
      exp_t e;
      exp_t got;
      int   size;
      int   nstale;
      bit   full;
      bit   fire;
      bit   cons;
      @(negedge clock);
      reset                    = rst;
      bus.req_valid            = rv;
      bus.mem_ready            = mr;
      bus.rsp_valid            = rsp;
      bus.flush_memory_issue   = fi;
      bus.flush_memory_receive = fr;

      size   = stale_q.size();
      nstale = 0;
      foreach (stale_q[k]) nstale += int'(stale_q[k]);
      full = (size == int'(MAX));
      fire = rv && mr && !full && !fi;
      cons = rsp && size > 0;
      e.req_fire       = int'(fire);
      e.issue_hazard   = int'(rv && !fi && (!mr || full));
      e.rsp_drop       = int'(cons && stale_q[0]);
      e.rsp_accept     = int'(cons && !stale_q[0]);
      e.recv_hazard    = int'((size - nstale) > 0 && e.rsp_accept == 0);
      e.outstanding    = size;
      e.drop_pending   = nstale;
      e.protocol_error = int'(model_err);
      if (!rst) e = '{default: 0};
      sb.push_back(e);

      #2;
      check("sb_nonempty", sb.size(), 1);
      if (sb.size() > 0) begin
         got = sb.pop_front();
         check("issue_hazard",   int'(bus.issue_hazard),   got.issue_hazard);
         check("recv_hazard",    int'(bus.recv_hazard),    got.recv_hazard);
         check("req_fire",       int'(bus.req_fire),       got.req_fire);
         check("rsp_accept",     int'(bus.rsp_accept),     got.rsp_accept);
         check("rsp_drop",       int'(bus.rsp_drop),       got.rsp_drop);
         check("outstanding",    int'(bus.outstanding),    got.outstanding);
         check("drop_pending",   int'(bus.drop_pending),   got.drop_pending);
         check("protocol_error", int'(bus.protocol_error), got.protocol_error);
      end

      if (!rst) begin
         stale_q.delete();
         model_err = 1'b0;
      end else begin
`ifdef MEM_TRACKER_CHECK_EN
         if ((rsp && size == 0) || (rsp && mr && rv && full)) model_err = 1'b1;
`endif
         if (cons) void'(stale_q.pop_front());
         if (fr) foreach (stale_q[k]) stale_q[k] = 1'b1;
         if (fire) stale_q.push_back(1'b0);
      end
   endtask

   initial begin
      tests     = 0;
      fails     = 0;
      model_err = 1'b0;
      reset     = 1'b0;
      bus.req_valid = 1'b0;
      bus.mem_ready = 1'b0;
      bus.rsp_valid = 1'b0;
      bus.flush_memory_issue   = 1'b0;
      bus.flush_memory_receive = 1'b0;

      // Reset state: outputs forced 0 even with active inputs
      step(0, 1, 1, 1, 0, 0);
      step(1, 0, 0, 0, 0, 0);

      // Fill to MAX, third request stalls
      step(1, 1, 1, 0, 0, 0);
      step(1, 1, 1, 0, 0, 0);
      step(1, 1, 1, 0, 0, 0);

      // Receive flush turns both in-flight requests stale, then drain as drops
      step(1, 0, 0, 0, 0, 1);
      step(1, 0, 0, 1, 0, 0);
      step(1, 0, 0, 1, 0, 0);
      step(1, 0, 0, 0, 0, 0);

      // One live, then fire + accept + receive flush in the same cycle
      step(1, 1, 1, 0, 0, 0);
      step(1, 1, 1, 1, 0, 1);
      step(1, 0, 0, 1, 0, 0);

      // Issue flush blocks firing; both flushes together
      step(1, 1, 1, 0, 1, 0);
      step(1, 1, 1, 0, 0, 0);
      step(1, 1, 1, 0, 1, 1);
      step(1, 0, 0, 1, 0, 0);

      // Spurious response with nothing outstanding
      step(1, 0, 0, 1, 0, 0);
      step(1, 0, 0, 0, 0, 0);

      // Reset mid-stream with two outstanding, late response afterwards
      step(1, 1, 1, 0, 0, 0);
      step(1, 1, 1, 0, 0, 0);
      step(0, 1, 1, 1, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 1, 0, 0);
      step(1, 0, 0, 0, 0, 0);

      // Random traffic
      for (int i = 0; i < 300; i++) begin
         step(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
              1'($urandom_range(0, 7) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
